bus_seq_ctrl: RTL and testbench

BUS_SEQ_CTRL -- requirements
Module: bus_seq_ctrl

---
 rtl/bus_seq_pkg.sv | 22 ++
 rtl/bus_seq_ctrl.sv | 116 +++++++++++
 tb/tb_bus_seq_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_seq_pkg.sv
// Shared types and helpers for the bus sequencing controller.
package bus_seq_pkg;

    localparam int unsigned MAX_REGS  = 8;
    localparam int unsigned MAX_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LOAD,
        DONE
    } state_t;

    // One-hot decode at the widest supported size; callers truncate to NUM_REGS.
    function automatic logic [MAX_REGS-1:0] sel_decode(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_REGS-1:0] dec;
        dec      = '0;
        dec[sel] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/bus_seq_ctrl.sv
// Register-to-register bus transfer sequencer (IDLE -> DRIVE -> LOAD -> DONE).
// Optional completed-transfer counter enabled by `define BUS_SEQ_XFER_CNT_EN.
module bus_seq_ctrl
    import bus_seq_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hlt,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [SEL_W-1:0]    cmd_src,
    input  logic [SEL_W-1:0]    cmd_dst,
    output logic [NUM_REGS-1:0] reg_enable,
    output logic [NUM_REGS-1:0] reg_load,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef BUS_SEQ_XFER_CNT_EN
    ,
    output logic [7:0]          xfer_cnt
`endif
);

    localparam logic [SEL_W:0] REG_LIMIT = (SEL_W + 1)'(NUM_REGS);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    src_q, src_d;
    logic [SEL_W-1:0]    dst_q, dst_d;
    logic [NUM_REGS-1:0] enable_d, load_d;
    logic                busy_d, done_d, err_d;
    logic                cmd_ok;

    // Ready is gated by hlt/rst directly so a halt blocks the handshake in the same cycle.
    assign cmd_ready = (state_q == IDLE) && !hlt && !rst;

    assign cmd_ok = (cmd_src != cmd_dst)
                 && ({1'b0, cmd_src} < REG_LIMIT)
                 && ({1'b0, cmd_dst} < REG_LIMIT);

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        enable_d = '0;
        load_d   = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_ok) begin
                        src_d   = cmd_src;
                        dst_d   = cmd_dst;
                        state_d = DRIVE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DRIVE:   state_d = LOAD;
            LOAD:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        case (state_d)
            DRIVE: enable_d = NUM_REGS'(sel_decode(MAX_SEL_W'(src_d)));
            LOAD: begin
                enable_d = NUM_REGS'(sel_decode(MAX_SEL_W'(src_d)));
                load_d   = NUM_REGS'(sel_decode(MAX_SEL_W'(dst_d)));
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            reg_enable <= '0;
            reg_load   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else if (!hlt) begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            reg_enable <= enable_d;
            reg_load   <= load_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

`ifdef BUS_SEQ_XFER_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (!hlt && done_d) begin
            xfer_cnt <= xfer_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_seq_ctrl.sv
// Self-checking bench for bus_seq_ctrl: directed scenarios plus randomized traffic
// against a transaction-phase reference model. Counter checks need BUS_SEQ_XFER_CNT_EN.
module tb_bus_seq_ctrl;

    localparam int NR = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hlt = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [SW-1:0] cmd_src = '0;
    logic [SW-1:0] cmd_dst = '0;
    logic [NR-1:0] reg_enable;
    logic [NR-1:0] reg_load;
    logic          busy;
    logic          done;
    logic          err;
`ifdef BUS_SEQ_XFER_CNT_EN
    logic [7:0]    xfer_cnt;
`endif

    int passed = 0;
    int total  = 0;

    // Reference model: cycles elapsed since the accepting handshake (0 = idle).
    int m_phase = 0;
    int m_src   = 0;
    int m_dst   = 0;
    bit m_err   = 1'b0;
    int m_cnt   = 0;

    bus_seq_ctrl #(.NUM_REGS(NR), .SEL_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .hlt        (hlt),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .reg_enable (reg_enable),
        .reg_load   (reg_load),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef BUS_SEQ_XFER_CNT_EN
        ,
        .xfer_cnt   (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_step();
        if (rst) begin
            m_phase = 0;
            m_err   = 1'b0;
            m_cnt   = 0;
        end else if (!hlt) begin
            m_err = 1'b0;
            if (m_phase == 0) begin
                if (cmd_valid) begin
                    if (cmd_src != cmd_dst && int'(cmd_src) < NR && int'(cmd_dst) < NR) begin
                        m_src   = int'(cmd_src);
                        m_dst   = int'(cmd_dst);
                        m_phase = 1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else begin
                m_phase = (m_phase + 1) % 4;
                if (m_phase == 3) m_cnt = (m_cnt + 1) % 256;
            end
        end
    endtask

    task automatic compare(input string tag);
        logic [NR-1:0] e_en;
        logic [NR-1:0] e_ld;
        bit            inv_ok;
        e_en = '0;
        e_ld = '0;
        if (m_phase == 1 || m_phase == 2) e_en[m_src] = 1'b1;
        if (m_phase == 2) e_ld[m_dst] = 1'b1;
        check({tag, ".enable"}, 32'(reg_enable), 32'(e_en));
        check({tag, ".load"},   32'(reg_load),   32'(e_ld));
        check({tag, ".busy"},   32'(busy),       32'(m_phase != 0));
        check({tag, ".done"},   32'(done),       32'(m_phase == 3));
        check({tag, ".err"},    32'(err),        32'(m_err));
        check({tag, ".ready"},  32'(cmd_ready),  32'(m_phase == 0 && !hlt && !rst));
`ifdef BUS_SEQ_XFER_CNT_EN
        check({tag, ".cnt"},    32'(xfer_cnt),   32'(m_cnt));
`endif
        inv_ok = ($countones(reg_enable) <= 1) && ($countones(reg_load) <= 1)
              && ((reg_load == '0) || (reg_enable != '0))
              && ((reg_load & reg_enable) == '0);
        check({tag, ".onehot_inv"}, 32'(inv_ok), 32'd1);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare(tag);
    endtask

    initial begin
        // Reset: cmd_ready low while rst is held, outputs cleared.
        tick("rst0");
        tick("rst1");
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Transfer src=0 -> dst=2 with junk on cmd_* during the transfer.
        cmd_valid = 1'b1; cmd_src = 2'd0; cmd_dst = 2'd2;
        tick("xfer_hs");
        check("xfer_p1_en", 32'(reg_enable), 32'h1);
        check("xfer_p1_ld", 32'(reg_load),   32'h0);
        cmd_src = 2'd3; cmd_dst = 2'd3;
        tick("xfer_p2");
        check("xfer_p2_en", 32'(reg_enable), 32'h1);
        check("xfer_p2_ld", 32'(reg_load),   32'h4);
        tick("xfer_p3");
        check("xfer_p3_done", 32'(done), 32'd1);
        check("xfer_p3_err",  32'(err),  32'd0);
        tick("xfer_p4");
        check("xfer_p4_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;

        // src == dst is rejected with a single-cycle err.
        cmd_valid = 1'b1; cmd_src = 2'd1; cmd_dst = 2'd1;
        tick("bad_hs");
        check("bad_err1",  32'(err),  32'd1);
        check("bad_busy1", 32'(busy), 32'd0);
        cmd_valid = 1'b0;
        tick("bad_after");
        check("bad_err2", 32'(err), 32'd0);

        // Halt held for 5 cycles while in LOAD.
        cmd_valid = 1'b1; cmd_src = 2'd3; cmd_dst = 2'd1;
        tick("hlt_hs");
        cmd_valid = 1'b0;
        tick("hlt_load");
        hlt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick("hlt_hold");
            check("hlt_hold_en", 32'(reg_enable), 32'h8);
            check("hlt_hold_ld", 32'(reg_load),   32'h2);
        end
        hlt = 1'b0;
        tick("hlt_release");
        check("hlt_done", 32'(done), 32'd1);
        tick("hlt_idle");

        // Reset during DRIVE aborts the transfer.
        cmd_valid = 1'b1; cmd_src = 2'd2; cmd_dst = 2'd0;
        tick("abort_hs");
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick("abort_rst");
        check("abort_en",   32'(reg_enable), 32'h0);
        check("abort_busy", 32'(busy),       32'd0);
        rst = 1'b0;
        tick("abort_after");
        check("abort_nodone", 32'(done), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            hlt       = ($urandom_range(0, 5) == 0);
            cmd_valid = $urandom_range(0, 1) == 1;
            cmd_src   = SW'($urandom_range(0, NR - 1));
            cmd_dst   = SW'($urandom_range(0, NR - 1));
            tick("rand");
        end
        rst = 1'b0; hlt = 1'b0; cmd_valid = 1'b0;

`ifdef BUS_SEQ_XFER_CNT_EN
        // Counter wraps back to zero after 256 transfers.
        rst = 1'b1;
        tick("cnt_rst");
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            cmd_valid = 1'b1; cmd_src = SW'(i % NR); cmd_dst = SW'((i + 1) % NR);
            tick("cnt_hs");
            cmd_valid = 1'b0;
            tick("cnt_p2");
            tick("cnt_p3");
            tick("cnt_p4");
        end
        check("cnt_wrap", 32'(xfer_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
